// File: rtl/vertex_rotator.sv
// Rotates one signed vertex about Z, X or Y using sine/cosine fetched from a downstream sine ROM.
// Define VERTEX_ROTATOR_ROUND_EN to round half up before the fixed-point shift; default truncates.
module vertex_rotator #(
   parameter int COORD_W   = 16,
   parameter int FRAC_BITS = 8,
   parameter int DEG_FULL  = 360
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   input  logic [COORD_W-1:0] in_z,
   input  logic [15:0]        in_angle,
   input  logic [1:0]         in_axis,
   output logic [15:0]        sin_angle,
   input  logic [15:0]        sin_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic [COORD_W-1:0] out_z,
   output logic               out_sat
);

   localparam int PROD_W = COORD_W + 16;
   localparam int SUM_W  = PROD_W + 1;
   localparam logic [15:0] DEG_FULL_W = 16'(DEG_FULL);
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((2 ** (COORD_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(-(2 ** (COORD_W - 1)));

   typedef enum logic [2:0] {ST_IDLE, ST_SIN, ST_COS, ST_MUL, ST_SUM, ST_OUT} state_t;

   state_t                     state_q, state_d;
   logic        [15:0]         sin_angle_q, sin_angle_d;
   logic signed [COORD_W-1:0]  out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
   logic                       out_sat_q, out_sat_d;
   logic signed [COORD_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
   logic        [1:0]          axis_q, axis_d;
   logic        [15:0]         thr_q, thr_d;
   logic signed [15:0]         s_q, s_d, c_q, c_d;
   logic signed [PROD_W-1:0]   p_ac_q, p_ac_d, p_bs_q, p_bs_d, p_as_q, p_as_d, p_bc_q, p_bc_d;

   logic        [15:0]         theta_r, theta_c;
   logic signed [COORD_W-1:0]  a_v, b_v;
   logic signed [SUM_W-1:0]    sum_a, sum_b;
   logic        [COORD_W:0]    res_a, res_b;

   function automatic logic signed [SUM_W-1:0] scale_sum(input logic signed [SUM_W-1:0] v);
`ifdef VERTEX_ROTATOR_ROUND_EN
      scale_sum = (v + SUM_W'(2 ** (FRAC_BITS - 1))) >>> FRAC_BITS;
`else
      scale_sum = v >>> FRAC_BITS;
`endif
   endfunction

   // Result packs {saturated flag, clipped coordinate}.
   function automatic logic [COORD_W:0] sat_coord(input logic signed [SUM_W-1:0] v);
      if (v > MAX_V)      sat_coord = {1'b1, MAX_V[COORD_W-1:0]};
      else if (v < MIN_V) sat_coord = {1'b1, MIN_V[COORD_W-1:0]};
      else                sat_coord = {1'b0, v[COORD_W-1:0]};
   endfunction

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_OUT);
   assign sin_angle = sin_angle_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_z     = out_z_q;
   assign out_sat   = out_sat_q;

   always_comb begin
      state_d     = state_q;
      sin_angle_d = sin_angle_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_z_d     = out_z_q;
      out_sat_d   = out_sat_q;
      x_d = x_q; y_d = y_q; z_d = z_q;
      axis_d = axis_q; thr_d = thr_q;
      s_d = s_q; c_d = c_q;
      p_ac_d = p_ac_q; p_bs_d = p_bs_q; p_as_d = p_as_q; p_bc_d = p_bc_q;

      theta_r = (in_angle >= DEG_FULL_W) ? in_angle - DEG_FULL_W : in_angle;
      theta_c = thr_q + 16'd90;
      if (theta_c >= DEG_FULL_W) theta_c = theta_c - DEG_FULL_W;

      // (a,b) is the rotated coordinate pair; the third axis passes through untouched.
      case (axis_q)
         2'd1:    begin a_v = y_q; b_v = z_q; end
         2'd2:    begin a_v = z_q; b_v = x_q; end
         default: begin a_v = x_q; b_v = y_q; end
      endcase

      sum_a = SUM_W'(p_ac_q) - SUM_W'(p_bs_q);
      sum_b = SUM_W'(p_as_q) + SUM_W'(p_bc_q);
      res_a = sat_coord(scale_sum(sum_a));
      res_b = sat_coord(scale_sum(sum_b));

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d         = $signed(in_x);
               y_d         = $signed(in_y);
               z_d         = $signed(in_z);
               axis_d      = in_axis;
               thr_d       = theta_r;
               sin_angle_d = theta_r;
               state_d     = ST_SIN;
            end
         end
         ST_SIN: begin
            s_d         = $signed(sin_data);
            sin_angle_d = theta_c;
            state_d     = ST_COS;
         end
         ST_COS: begin
            c_d     = $signed(sin_data);
            state_d = ST_MUL;
         end
         ST_MUL: begin
            p_ac_d  = PROD_W'(a_v) * PROD_W'(c_q);
            p_bs_d  = PROD_W'(b_v) * PROD_W'(s_q);
            p_as_d  = PROD_W'(a_v) * PROD_W'(s_q);
            p_bc_d  = PROD_W'(b_v) * PROD_W'(c_q);
            state_d = ST_SUM;
         end
         ST_SUM: begin
            out_sat_d = (axis_q != 2'd3) && (res_a[COORD_W] || res_b[COORD_W]);
            case (axis_q)
               2'd0: begin
                  out_x_d = $signed(res_a[COORD_W-1:0]);
                  out_y_d = $signed(res_b[COORD_W-1:0]);
                  out_z_d = z_q;
               end
               2'd1: begin
                  out_x_d = x_q;
                  out_y_d = $signed(res_a[COORD_W-1:0]);
                  out_z_d = $signed(res_b[COORD_W-1:0]);
               end
               2'd2: begin
                  out_x_d = $signed(res_b[COORD_W-1:0]);
                  out_y_d = y_q;
                  out_z_d = $signed(res_a[COORD_W-1:0]);
               end
               default: begin
                  out_x_d = x_q;
                  out_y_d = y_q;
                  out_z_d = z_q;
               end
            endcase
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sin_angle_q <= '0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_z_q     <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sin_angle_q <= sin_angle_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_z_q     <= out_z_d;
         out_sat_q   <= out_sat_d;
      end
   end

   // Datapath holding registers carry no reset; the FSM gates when they are meaningful.
   always_ff @(posedge clk) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      axis_q <= axis_d;
      thr_q  <= thr_d;
      s_q    <= s_d;
      c_q    <= c_d;
      p_ac_q <= p_ac_d;
      p_bs_q <= p_bs_d;
      p_as_q <= p_as_d;
      p_bc_q <= p_bc_d;
   end

endmodule

// File: tb/tb_vertex_rotator.sv
// Directed table-driven bench for vertex_rotator with a small sine ROM model.
module tb_vertex_rotator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x, in_y, in_z;
   logic [15:0] in_angle;
   logic [1:0]  in_axis;
   logic [15:0] sin_angle;
   logic [15:0] sin_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_x, out_y, out_z;
   logic        out_sat;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vertex_rotator dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .in_angle(in_angle), .in_axis(in_axis),
      .sin_angle(sin_angle), .sin_data(sin_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_sat(out_sat)
   );

   function automatic logic [15:0] sine_model(input logic [15:0] a);
      case (a)
         16'd45, 16'd135: sine_model = 16'd181;
         16'd60:          sine_model = 16'd222;
         16'd90:          sine_model = 16'd256;
         16'd150:         sine_model = 16'd128;
         16'd270:         sine_model = 16'hFF00;
         default:         sine_model = 16'd0;
      endcase
   endfunction

   assign sin_data = sine_model(sin_angle);

   typedef struct {
      int x, y, z, ang, axis;
      int ex, ey, ez, esat;
      int sa, ca, hold;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input vec_t v);
      check({name, "_x"}, int'($signed(out_x)), v.ex);
      check({name, "_y"}, int'($signed(out_y)), v.ey);
      check({name, "_z"}, int'($signed(out_z)), v.ez);
      check({name, "_sat"}, int'(out_sat), v.esat);
   endtask

   task automatic start_vec(input vec_t v);
      @(negedge clk);
      in_x     = 16'(v.x);
      in_y     = 16'(v.y);
      in_z     = 16'(v.z);
      in_angle = 16'(v.ang);
      in_axis  = 2'(v.axis);
      in_valid = 1'b1;
      check("in_ready_idle", int'(in_ready), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int cyc;
      start_vec(v);
      check({name, "_rdy_busy"}, int'(in_ready), 0);
      @(negedge clk);
      check({name, "_sin_ang"}, int'(sin_angle), v.sa);
      @(negedge clk);
      check({name, "_cos_ang"}, int'(sin_angle), v.ca);
      cyc = 2;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      check({name, "_latency"}, cyc, 5);
      check_outs(name, v);
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk);
         #1;
         check({name, "_hold_vld"}, int'(out_valid), 1);
         check_outs({name, "_hold"}, v);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({name, "_rdy_after"}, int'(in_ready), 1);
      check({name, "_vld_after"}, int'(out_valid), 0);
   endtask

   initial begin
      int rnd1;
`ifdef VERTEX_ROTATOR_ROUND_EN
      rnd1 = 1;
`else
      rnd1 = 0;
`endif
      //            x      y      z    ang ax   ex      ey     ez   sat sa   ca  hold
      vecs[0] = '{100,    50,    7,    0,  0,  100,    50,    7,   0,  0,   90,  0};
      vecs[1] = '{100,    50,    7,  450,  0,  -50,   100,    7,   0, 90,  180,  0};
      vecs[2] = '{32767, 32767,  0,   45,  0,    0, 32767,    0,   1, 45,  135,  3};
      vecs[3] = '{1,      0,     0,   60,  0, rnd1,  rnd1,    0,   0, 60,  150,  0};
      vecs[4] = '{5,      0,   -40,  270,  1,    5,   -40,    0,   0, 270,   0,  0};
      vecs[5] = '{5,      0,   -40,  270,  3,    5,     0,  -40,   0, 270,   0,  0};
      vecs[6] = '{100,    9,    50,   90,  2,   50,     9, -100,   0, 90,  180,  0};
      vecs[7] = '{-32768, 32767, 3,   45,  0, -32768,  -1,    3,   1, 45,  135,  0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_x = '0; in_y = '0; in_z = '0; in_angle = '0; in_axis = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_x", int'(out_x), 0);
      check("rst_out_y", int'(out_y), 0);
      check("rst_out_z", int'(out_z), 0);
      check("rst_out_sat", int'(out_sat), 0);
      check("rst_sin_angle", int'(sin_angle), 0);

      for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Abort during SUM: accept edge, then SIN, COS, MUL, SUM entered on the 4th edge.
      start_vec(vecs[1]);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_x", int'(out_x), 0);
      check("abort_out_y", int'(out_y), 0);
      check("abort_out_z", int'(out_z), 0);
      check("abort_out_sat", int'(out_sat), 0);
      check("abort_sin_angle", int'(sin_angle), 0);
      run_vec("post_abort", vecs[6]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
